// File: rtl/core_pkg.sv
// core_pkg: shared next-PC source encodings and fixed ROM vectors for the MIPS32 core
package core_pkg;
  localparam logic [2:0] PC_SEQ    = 3'd0;
  localparam logic [2:0] PC_BRANCH = 3'd1;
  localparam logic [2:0] PC_JUMP   = 3'd2;
  localparam logic [2:0] PC_JR     = 3'd3;
  localparam logic [2:0] PC_XADR   = 3'd5;
  localparam logic [31:0] RESET_VEC = 32'h8000_0000;
  localparam logic [31:0] ILLOP_VEC = 32'h8000_0004;
  localparam logic [31:0] XADR_VEC  = 32'h8000_0008;
endpackage

// File: rtl/irq_sync.sv
// irq_sync: two-flop synchronizer for the external interrupt plus a pending latch held until taken
module irq_sync (
  input  logic clk,
  input  logic reset,
  input  logic irq,
  input  logic clr,
  output logic pend
);
  logic sync1, sync2;
  // Resynchronize irq and latch it; taking the interrupt clears the latch first
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      pend  <= 1'b0;
    end else begin
      sync1 <= irq;
      sync2 <= sync1;
      pend  <= clr ? 1'b0 : (pend | sync2);
    end
endmodule

// File: rtl/pc_fetch.sv
// pc_fetch: program counter, next-address selection, supervisor bit and interrupt acceptance
module pc_fetch #(
  parameter logic [31:0] RESET_VEC = core_pkg::RESET_VEC,
  parameter logic [31:0] ILLOP_VEC = core_pkg::ILLOP_VEC,
  parameter logic [31:0] XADR_VEC  = core_pkg::XADR_VEC
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [2:0]  pc_src,
  input  logic        branch_taken,
  input  logic [15:0] imm16,
  input  logic [25:0] jtarget,
  input  logic [31:0] jr_target,
  input  logic        irq,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic        irq_take,
  output logic [31:0] xp_data
);
  import core_pkg::*;
  logic        irq_pend;
  logic [30:0] br_off, br_sum;
  logic [31:0] next_pc;
  irq_sync u_irq_sync (.clk(clk), .reset(reset), .irq(irq), .clr(irq_take), .pend(irq_pend));
  assign irq_take = irq_pend & ~pc[31];
  assign pc_plus4 = {pc[31], pc[30:0] + 31'd4};
  assign xp_data  = irq_take ? pc : pc_plus4;
  assign br_off   = {{13{imm16[15]}}, imm16, 2'b00};
  assign br_sum   = pc_plus4[30:0] + br_off;
  // Select the next PC; the supervisor bit only survives a JR when both old and target bit31 are set
  always_comb
    next_pc = irq_take                             ? ILLOP_VEC :
              pc_src == PC_XADR                    ? XADR_VEC :
              pc_src == PC_JR                      ? {pc[31] & jr_target[31], jr_target[30:0]} :
              pc_src == PC_JUMP                    ? {pc[31], pc_plus4[30:28], jtarget, 2'b00} :
              (pc_src == PC_BRANCH && branch_taken) ? {pc[31], br_sum} :
                                                     pc_plus4;
  // PC register; fetch addresses are always word aligned
  always_ff @(posedge clk or posedge reset)
    if (reset) pc <= RESET_VEC;
    else pc <= next_pc & 32'hFFFF_FFFC;
endmodule

// File: tb/tb_pc_fetch.sv
// tb_pc_fetch: directed checks of next-PC selection, supervisor bit and interrupt timing
module tb_pc_fetch;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [2:0]  pc_src = 3'd0;
  logic        branch_taken = 1'b0;
  logic [15:0] imm16 = 16'h0;
  logic [25:0] jtarget = 26'h0;
  logic [31:0] jr_target = 32'h0;
  logic        irq = 1'b0;
  logic [31:0] pc, pc_plus4, xp_data;
  logic        irq_take;
  int checks = 0;
  int failures = 0;

  pc_fetch dut (.clk(clk), .reset(reset), .pc_src(pc_src), .branch_taken(branch_taken),
                .imm16(imm16), .jtarget(jtarget), .jr_target(jr_target), .irq(irq),
                .pc(pc), .pc_plus4(pc_plus4), .irq_take(irq_take), .xp_data(xp_data));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic jr_to(input logic [31:0] t);
    pc_src = 3'd3;
    jr_target = t;
    step();
    pc_src = 3'd0;
  endtask

  initial begin
    @(negedge clk);
    @(negedge clk);
    chk("reset_pc", pc, 32'h8000_0000);
    chk("reset_take", {31'b0, irq_take}, 32'h0);
    reset = 1'b0;
    step();
    step();
    chk("seq_run", pc, 32'h8000_0008);
    #2 reset = 1'b1;
    #1;
    chk("async_reset_pc", pc, 32'h8000_0000);
    chk("async_reset_p4", pc_plus4, 32'h8000_0004);
    @(negedge clk);
    reset = 1'b0;
    step();
    step();
    step();
    chk("seq3_pc", pc, 32'h8000_000C);
    chk("seq3_p4", pc_plus4, 32'h8000_0010);
    pc_src = 3'd4;
    step();
    chk("src4_as_seq", pc, 32'h8000_0010);
    pc_src = 3'd2;
    jtarget = 26'h0000035;
    step();
    chk("jump", pc, 32'h8000_00D4);
    jr_to(32'h0000_0060);
    chk("kjr_user", pc, 32'h0000_0060);
    pc_src = 3'd1;
    branch_taken = 1'b1;
    imm16 = 16'hFFFD;
    step();
    chk("branch_taken", pc, 32'h0000_0058);
    jr_to(32'h0000_0060);
    pc_src = 3'd1;
    branch_taken = 1'b0;
    step();
    chk("branch_not_taken", pc, 32'h0000_0064);
    jr_to(32'h0000_0040);
    jr_to(32'h8000_0000);
    chk("user_jr_no_sup", pc, 32'h0000_0000);
    pc_src = 3'd5;
    #1;
    chk("xadr_xp", xp_data, 32'h0000_0004);
    step();
    pc_src = 3'd0;
    chk("xadr_pc", pc, 32'h8000_0008);
    jr_to(32'h8000_02BC);
    chk("kjr_stay_sup", pc, 32'h8000_02BC);
    jr_to(32'h0000_0048);
    chk("kernel_return", pc, 32'h0000_0048);
    jr_to(32'h0000_0063);
    chk("jr_misaligned", pc, 32'h0000_0060);
    irq = 1'b1;
    step();
    chk("irq_n", {31'b0, irq_take}, 32'h0);
    step();
    chk("irq_n1", {31'b0, irq_take}, 32'h0);
    step();
    chk("irq_n2_take", {31'b0, irq_take}, 32'h1);
    chk("irq_n2_xp", xp_data, 32'h0000_006C);
    step();
    chk("irq_vec", pc, 32'h8000_0004);
    chk("irq_masked0", {31'b0, irq_take}, 32'h0);
    step();
    step();
    chk("irq_masked2", {31'b0, irq_take}, 32'h0);
    irq = 1'b0;
    jr_to(32'h0000_0020);
    chk("irq_after_ret", {31'b0, irq_take}, 32'h1);
    pc_src = 3'd5;
    #1;
    chk("simul_xp", xp_data, 32'h0000_0020);
    step();
    pc_src = 3'd0;
    chk("simul_pc", pc, 32'h8000_0004);
    jr_to(32'h0000_0100);
    chk("pend_cleared", {31'b0, irq_take}, 32'h0);
    irq = 1'b1;
    step();
    step();
    step();
    chk("pend_before_rst", {31'b0, irq_take}, 32'h1);
    #2 reset = 1'b1;
    irq = 1'b0;
    #1;
    chk("rst_mid_pc", pc, 32'h8000_0000);
    @(negedge clk);
    reset = 1'b0;
    jr_to(32'h0000_0010);
    chk("rst_discard_pend", {31'b0, irq_take}, 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
